imem_fetch_sequencer: RTL
=========================

# imem_fetch_sequencer

Fetch controller that sequences the combinational instruction memory for the MIPS core. It owns the program counter, drives the instruction-memory address, captures each returned word together with its PC into a 2-entry fetch buffer, and hands instructions to decode over a valid/ready handshake. It also applies branch/jump redirects from execute, honours a halt request, and flags misaligned redirect targets.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset (must be a multiple of 4).
- DEPTH, 2: fetch-buffer entries (fixed at 2 for this design).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory (equals the PC register).
- imem_rdata  in  32  instruction word; combinational from imem_addr, same cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  redirect target byte address.
- halt  in  1  level request to stop fetching.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at buffer head.
- out_pc  out  32  byte address of out_instr.
- fetch_count  out  32  count of instructions accepted by decode.
- fault  out  1  sticky misaligned-redirect error.

## Operation

- States: BOOT, RUN, HALT, FAULT.
- Reset (asynchronous) forces BOOT, pc=RESET_PC, buffer empty, all entries 0, fetch_count=0, fault=0. Outputs during reset: imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- BOOT: no push. Goes to RUN on the next edge, or to HALT if halt=1.
- RUN: push {pc, imem_rdata} and set pc=pc+4 when count<2 or a pop occurs this cycle. If halt=1 at the edge, go to HALT; no push on that edge.
- HALT: no push and pc is held. The buffer still drains to decode. Returns to RUN on the first edge with halt=0; fetch resumes on the following edge.
- FAULT: entered when redirect_valid=1 and redirect_pc[1:0]!=0, in any state. On that edge the buffer is flushed and fault=1. In FAULT, pc is held, nothing is pushed and out_valid=0. Only reset leaves FAULT.
- Pop: out_valid & out_ready. Removes the head entry and increments fetch_count (32-bit, wraps 0xFFFF_FFFF→0).
- Redirect (aligned), priority below reset and above everything else:
  - flushes both buffer entries and sets pc=redirect_pc;
  - suppresses the push on that edge;
  - a same-cycle handshake is discarded and does not increment fetch_count;
  - redirect in HALT updates pc and flushes, and the state stays HALT;
  - redirect in BOOT updates pc and the state proceeds to RUN.
- Push and pop in the same cycle are legal at any count, including full; count is then unchanged.
- Full (count=2) with no pop: no push, pc is held, and imem_addr remains stable.
- pc wraps 0xFFFF_FFFC→0x0000_0000 with no error.
- out_valid = (count!=0) and state!=FAULT. out_instr/out_pc come from the head register, not directly from imem_rdata.

## Timing

- imem_addr is registered: it changes only on clock edges or asynchronously on reset.
- Reset deassertion: edge 1 BOOT→RUN; edge 2 pushes the word at RESET_PC; out_valid=1 after edge 2.
- Redirect sampled at edge N: out_valid=0 after N; the target instruction is pushed at N+1, with out_valid=1 and out_pc=target after N+1.
- Throughput: with out_ready held at 1, one instruction per cycle.
- Halt sampled at edge N: no push at N. With an empty buffer, out_valid=0 after N.
- Fault: fault=1 and out_valid=0 immediately after the offending edge.

## Test plan

- Memory holds 0x20080005@0, 0x20090007@4, 0x01095020@8, and out_ready=1. Release reset → out_pc 0,4,8 with those words on consecutive cycles starting after the 2nd edge; fetch_count reaches 3.
- Backpressure: out_ready=0 for 5 cycles after the first valid → buffer holds PC 0 and 4 and imem_addr stays 8. Raise out_ready → 0,4,8 are delivered in order with no loss or duplicate.
- Redirect to 0x40 while head is PC 4 and out_ready=1 → next valid out_pc=0x40; PC 4 and 8 are never accepted; fetch_count is not incremented for the discarded handshake.
- halt=1 for 3 cycles mid-stream → buffered entries drain, then out_valid=0 and imem_addr is held. Drop halt → fetch resumes from the held PC with no skipped address.
- Redirect to 0x42 → fault=1 and out_valid=0 from the next edge, persisting while redirects/halt toggle. Assert reset → fault=0 and imem_addr=RESET_PC.
- Assert reset asynchronously mid-stream with a full buffer → out_valid=0 and imem_addr=RESET_PC before the next clock edge; fetch_count=0.

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer for the MIPS core: owns the PC, reads the combinational
// instruction memory and queues {pc, instr} pairs in a 2-entry buffer for decode.
module imem_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] fetch_count,
    output logic        fault
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    entry_t        head_q, head_d;
    entry_t        tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   fcnt_q, fcnt_d;
    logic          fault_q, fault_d;
    logic          valid_q, valid_d;
    logic          pop, push, misaligned;
    entry_t        fetched;

    assign imem_addr   = pc_q;
    assign out_valid   = valid_q;
    assign out_instr   = head_q.instr;
    assign out_pc      = head_q.pc;
    assign fetch_count = fcnt_q;
    assign fault       = fault_q;

    // Next-state: misaligned redirect > redirect > normal fetch/drain.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        fault_d    = fault_q;
        push       = 1'b0;
        fetched    = {pc_q, imem_rdata};
        misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
        pop        = valid_q && out_ready;

        if (misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
            cnt_d   = '0;
            head_d  = '0;
            tail_d  = '0;
        end else if (state_q != FAULT) begin
            if (redirect_valid) begin
                // Same-cycle handshake is dropped along with the flushed entries.
                cnt_d   = '0;
                head_d  = '0;
                tail_d  = '0;
                pc_d    = redirect_pc;
                state_d = (state_q == HALT || halt) ? HALT : RUN;
            end else begin
                if (pop) begin
                    fcnt_d = fcnt_q + 32'd1;
                end
                case (state_q)
                    BOOT: state_d = halt ? HALT : RUN;
                    RUN: begin
                        if (halt) begin
                            state_d = HALT;
                        end else begin
                            push = (cnt_q != CW'(DEPTH)) || pop;
                        end
                    end
                    HALT: begin
                        if (!halt) begin
                            state_d = RUN;
                        end
                    end
                    default: state_d = state_q;
                endcase

                if (push) begin
                    pc_d = pc_q + 32'd4;
                end

                if (pop && push) begin
                    if (cnt_q == CW'(1)) begin
                        head_d = fetched;
                    end else begin
                        head_d = tail_q;
                        tail_d = fetched;
                    end
                end else if (pop) begin
                    head_d = tail_q;
                    tail_d = '0;
                    cnt_d  = cnt_q - CW'(1);
                end else if (push) begin
                    if (cnt_q == '0) begin
                        head_d = fetched;
                    end else begin
                        tail_d = fetched;
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        valid_d = (cnt_d != '0) && (state_d != FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            fault_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            fault_q <= fault_d;
            valid_q <= valid_d;
        end
    end

endmodule
